// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// instruction field positions, FSM states and decoded instruction classes.
package cpu_pkg;

    localparam int INSN_W  = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 9;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 5;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_DEC  = 4'b1011;
    localparam logic [3:0] OP_DJNZ = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1111;
    localparam logic [3:0] OP_HLT  = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_RD1,
        S_RD2,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD,
        CLS_JMP,
        CLS_HLT
    } insn_class_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control-unit side of the datapath: instruction ROM, register file and ALU
// signals. The control unit is the master; the datapath blocks are the slave.
interface cpu_control_unit_if #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
);
    logic [PC_W-1:0]   pc;
    logic              ir_en;
    logic [15:0]       ir_data;
    logic [1:0]        reg_addr;
    logic              reg_rd;
    logic              reg_wr;
    logic [DATA_W-1:0] reg_din;
    logic [DATA_W-1:0] reg_dout;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;

    modport master (
        output pc, ir_en, reg_addr, reg_rd, reg_wr, reg_din,
               alu_opcode, alu_a, alu_b,
        input  ir_data, reg_dout, alu_out
    );

    modport slave (
        input  pc, ir_en, reg_addr, reg_rd, reg_wr, reg_din,
               alu_opcode, alu_a, alu_b,
        output ir_data, reg_dout, alu_out
    );
endinterface

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: splits an instruction word into its
// class, register fields, immediate, ALU code and sequencing flags.
module cu_decoder
    import cpu_pkg::*;
(
    input  logic [INSN_W-1:0] ir,
    output insn_class_t       cls,
    output logic [1:0]        rd,
    output logic [1:0]        rs1,
    output logic [1:0]        rs2,
    output logic [7:0]        imm,
    output logic [2:0]        alu_code,
    output logic              needs_rs2,
    output logic              writes_rd,
    output logic              is_branch
);

    logic unused_ir_bits;

    assign rd             = ir[RD_MSB:RD_LSB];
    assign rs1            = ir[RS1_MSB:RS1_LSB];
    assign rs2            = ir[RS2_MSB:RS2_LSB];
    assign imm            = ir[IMM_MSB:IMM_LSB];
    assign unused_ir_bits = ^ir[11:10];

    // Unlisted opcodes fall through to NOP.
    always_comb begin
        cls       = CLS_NOP;
        alu_code  = ALU_ADD;
        needs_rs2 = 1'b0;
        writes_rd = 1'b0;
        is_branch = 1'b0;
        unique case (ir[OP_MSB:OP_LSB])
            OP_ADD: begin
                cls       = CLS_ALU;
                needs_rs2 = 1'b1;
                writes_rd = 1'b1;
            end
            OP_SUB: begin
                cls       = CLS_ALU;
                alu_code  = ALU_SUB;
                needs_rs2 = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                cls       = CLS_LOAD;
                writes_rd = 1'b1;
            end
            OP_INC: begin
                cls       = CLS_ALU;
                writes_rd = 1'b1;
            end
            OP_DEC: begin
                cls       = CLS_ALU;
                alu_code  = ALU_SUB;
                writes_rd = 1'b1;
            end
            OP_DJNZ: begin
                cls       = CLS_ALU;
                alu_code  = ALU_SUB;
                writes_rd = 1'b1;
                is_branch = 1'b1;
            end
            OP_JMP: begin
                cls       = CLS_JMP;
                is_branch = 1'b1;
            end
            OP_HLT: cls = CLS_HLT;
            default: cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired multi-cycle control unit: fetch, decode, operand read, execute and
// write-back for the 8-bit processor. Optional CU_INSN_COUNT_EN adds insn_count.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cpu_control_unit_if.master bus,
    output logic               halted
`ifdef CU_INSN_COUNT_EN
    ,
    output logic [15:0]        insn_count
`endif
);

    state_t            state;
    logic [INSN_W-1:0] ir;
    logic [INSN_W-1:0] dec_ir;
    insn_class_t       dec_cls;
    logic [1:0]        dec_rd;
    logic [1:0]        dec_rs1;
    logic [1:0]        dec_rs2;
    logic [7:0]        dec_imm;
    logic [2:0]        dec_alu;
    logic              dec_needs_rs2;
    logic              dec_writes_rd;
    logic              dec_is_branch;

    // In DECODE the word is still on the ROM bus, so decode it directly.
    assign dec_ir = (state == S_DECODE) ? bus.ir_data : ir;

    cu_decoder u_decoder (
        .ir        (dec_ir),
        .cls       (dec_cls),
        .rd        (dec_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .imm       (dec_imm),
        .alu_code  (dec_alu),
        .needs_rs2 (dec_needs_rs2),
        .writes_rd (dec_writes_rd),
        .is_branch (dec_is_branch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_FETCH;
            ir             <= '0;
            bus.pc         <= '0;
            bus.ir_en      <= 1'b0;
            bus.reg_addr   <= '0;
            bus.reg_rd     <= 1'b0;
            bus.reg_wr     <= 1'b0;
            bus.reg_din    <= '0;
            bus.alu_opcode <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            halted         <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    bus.ir_en  <= 1'b1;
                    bus.reg_wr <= 1'b0;
                    state      <= S_DECODE;
                end
                S_DECODE: begin
                    bus.ir_en <= 1'b0;
                    ir        <= bus.ir_data;
                    unique case (dec_cls)
                        CLS_LOAD: state <= S_WB;
                        CLS_JMP: begin
                            bus.pc <= PC_W'(dec_imm);
                            state  <= S_FETCH;
                        end
                        CLS_HLT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        CLS_ALU: begin
                            bus.reg_addr <= dec_needs_rs2 ? dec_rs1 : dec_rd;
                            bus.reg_rd   <= 1'b1;
                            state        <= S_RD1;
                        end
                        default: begin
                            bus.pc <= bus.pc + PC_W'(1);
                            state  <= S_FETCH;
                        end
                    endcase
                end
                S_RD1: begin
                    bus.alu_a <= bus.reg_dout;
                    if (dec_needs_rs2) begin
                        bus.reg_addr <= dec_rs2;
                        state        <= S_RD2;
                    end else begin
                        bus.alu_b  <= DATA_W'(1);
                        bus.reg_rd <= 1'b0;
                        state      <= S_EXEC;
                    end
                end
                S_RD2: begin
                    bus.alu_b  <= bus.reg_dout;
                    bus.reg_rd <= 1'b0;
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    bus.alu_opcode <= dec_alu;
                    state          <= S_WB;
                end
                S_WB: begin
                    bus.reg_wr   <= dec_writes_rd;
                    bus.reg_addr <= dec_rd;
                    bus.reg_din  <= (dec_cls == CLS_LOAD) ? DATA_W'(dec_imm) : bus.alu_out;
                    // Only DJNZ reaches write-back with the branch flag set.
                    if (dec_is_branch && (bus.alu_out != '0)) begin
                        bus.pc <= PC_W'(dec_imm);
                    end else begin
                        bus.pc <= bus.pc + PC_W'(1);
                    end
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef CU_INSN_COUNT_EN
    logic retire;

    // An instruction retires when it leaves WB, or leaves DECODE without needing WB.
    assign retire = (state == S_WB) ||
                    ((state == S_DECODE) && (dec_cls inside {CLS_NOP, CLS_JMP, CLS_HLT}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_count <= '0;
        end else if (retire) begin
            insn_count <= insn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed programs plus random
// programs compared against an instruction-level reference interpreter.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halted;
    logic        reg_init;
    logic [15:0] rom [256];
    logic [7:0]  regs [4];
    logic [7:0]  init_regs [4];
    int          checks = 0;
    int          errors = 0;
    int          dut_cycles;
    int          overlap;
    bit          saw_wrap;
    logic [7:0]  prev_pc;
    int          m_cycles;
    int          m_retired;
    int          m_pc;
    bit          m_halted;
    logic [7:0]  m_regs [4];
`ifdef CU_INSN_COUNT_EN
    logic [15:0] insn_count;
`endif

    always #5 clk = ~clk;

    cpu_control_unit_if #(.PC_W(8), .DATA_W(8)) bus ();

    cpu_control_unit #(.PC_W(8), .DATA_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .halted (halted)
`ifdef CU_INSN_COUNT_EN
        ,
        .insn_count (insn_count)
`endif
    );

    // Datapath stand-ins: ROM and register file answer in the cycle after the request.
    assign bus.ir_data  = bus.ir_en ? rom[bus.pc] : 16'hC000;
    assign bus.reg_dout = bus.reg_rd ? regs[bus.reg_addr] : 8'h00;
    assign bus.alu_out  = (bus.alu_opcode == 3'b001) ? bus.alu_a - bus.alu_b
                                                     : bus.alu_a + bus.alu_b;

    always @(posedge clk) begin
        if (reg_init) begin
            for (int i = 0; i < 4; i++) regs[i] <= init_regs[i];
        end else if (bus.reg_wr) begin
            regs[bus.reg_addr] <= bus.reg_din;
        end
    end

    function automatic logic [15:0] rrr(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, 2'b00, rd, 2'b00, rs1, 2'b00, rs2};
    endfunction

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [7:0] imm);
        return {op, 2'b00, rd, imm};
    endfunction

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 16'hC000;
        for (int i = 0; i < 4; i++) init_regs[i] = 8'h00;
    endtask

    // Instruction-set interpreter: architectural effect plus cycles-per-instruction.
    task automatic model_run();
        int          p;
        logic [15:0] w;
        logic [7:0]  r [4];
        logic [1:0]  rd;
        logic [7:0]  imm;
        p = 0;
        m_cycles = 0;
        m_retired = 0;
        m_halted = 1'b0;
        for (int i = 0; i < 4; i++) r[i] = init_regs[i];
        for (int step = 0; step < 5000 && !m_halted; step++) begin
            w   = rom[p];
            rd  = w[9:8];
            imm = w[7:0];
            m_retired++;
            case (w[15:12])
                4'h0: begin r[rd] = r[w[5:4]] + r[w[1:0]]; p = (p + 1) % 256; m_cycles += 6; end
                4'h1: begin r[rd] = r[w[5:4]] - r[w[1:0]]; p = (p + 1) % 256; m_cycles += 6; end
                4'h8: begin r[rd] = imm; p = (p + 1) % 256; m_cycles += 3; end
                4'hA: begin r[rd] = r[rd] + 8'd1; p = (p + 1) % 256; m_cycles += 5; end
                4'hB: begin r[rd] = r[rd] - 8'd1; p = (p + 1) % 256; m_cycles += 5; end
                4'hE: begin
                    r[rd] = r[rd] - 8'd1;
                    p = (r[rd] != 8'd0) ? int'(imm) : (p + 1) % 256;
                    m_cycles += 5;
                end
                4'hF: begin p = int'(imm); m_cycles += 2; end
                4'hC: begin m_halted = 1'b1; m_cycles += 2; end
                default: begin p = (p + 1) % 256; m_cycles += 2; end
            endcase
        end
        m_pc = p;
        for (int i = 0; i < 4; i++) m_regs[i] = r[i];
    endtask

    task automatic start_dut();
        rst_n = 1'b0;
        reg_init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reg_init = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Cycles are counted from the first FETCH edge to the edge that raises halted.
    task automatic run_dut(input int limit);
        start_dut();
        dut_cycles = 0;
        overlap = 0;
        saw_wrap = 1'b0;
        prev_pc = bus.pc;
        while (halted !== 1'b1 && dut_cycles < limit) begin
            @(posedge clk);
            #1;
            dut_cycles++;
            if (bus.reg_rd === 1'b1 && bus.reg_wr === 1'b1) overlap++;
            if (prev_pc == 8'hFF && bus.pc == 8'h00) saw_wrap = 1'b1;
            prev_pc = bus.pc;
        end
        checks++;
        if (halted !== 1'b1)
            $display("[TB] FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, dut_cycles);
    endtask

    task automatic check_run(input string tag);
        model_run();
        run_dut(20000);
        checks++;
        if (bus.pc !== 8'(m_pc)) begin
            errors++;
            $display("[TB] FAIL %s pc: got %0d required %0d", tag, bus.pc, m_pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (regs[i] !== m_regs[i]) begin
                errors++;
                $display("[TB] FAIL %s R%0d: got %0d required %0d", tag, i, regs[i], m_regs[i]);
            end
        end
        checks++;
        if (dut_cycles !== m_cycles - 1) begin
            errors++;
            $display("[TB] FAIL %s cycles: got %0d required %0d", tag, dut_cycles, m_cycles - 1);
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("[TB] FAIL %s rd_wr_overlap: got %0d cycles required 0", tag, overlap);
        end
`ifdef CU_INSN_COUNT_EN
        checks++;
        if (insn_count !== 16'(m_retired)) begin
            errors++;
            $display("[TB] FAIL %s insn_count: got %0d required %0d", tag, insn_count, m_retired);
        end
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (halted !== 1'b1 || bus.pc !== 8'(m_pc)) begin
            errors++;
            $display("[TB] FAIL %s halt_hold: halted=%0b pc=%0d required halted=1 pc=%0d",
                     tag, halted, bus.pc, m_pc);
        end
    endtask

    task automatic test_reset();
        clear_rom();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.pc, bus.ir_en, bus.reg_addr, bus.reg_rd, bus.reg_wr, bus.reg_din,
             bus.alu_opcode, bus.alu_a, bus.alu_b, halted} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: pc=%0d ir_en=%0b rd=%0b wr=%0b halted=%0b required all 0",
                     bus.pc, bus.ir_en, bus.reg_rd, bus.reg_wr, halted);
        end
`ifdef CU_INSN_COUNT_EN
        checks++;
        if (insn_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d required 0", insn_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ir_en !== 1'b1 || bus.pc !== 8'd0) begin
            errors++;
            $display("[TB] FAIL first_fetch: ir_en=%0b pc=%0d required ir_en=1 pc=0", bus.ir_en, bus.pc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hlt_at_zero: halted=%0b required 1", halted);
        end
    endtask

    task automatic test_load_add();
        clear_rom();
        rom[0] = ri(4'h8, 2'd0, 8'd5);
        rom[1] = ri(4'h8, 2'd1, 8'd3);
        rom[2] = rrr(4'h0, 2'd2, 2'd0, 2'd1);
        rom[3] = 16'hC000;
        check_run("load_add");
        checks++;
        if (regs[2] !== 8'd8 || bus.pc !== 8'd3 || dut_cycles !== 13) begin
            errors++;
            $display("[TB] FAIL load_add_spec: R2=%0d pc=%0d cycles=%0d required 8 3 13",
                     regs[2], bus.pc, dut_cycles);
        end
`ifdef CU_INSN_COUNT_EN
        checks++;
        if (insn_count !== 16'd4) begin
            errors++;
            $display("[TB] FAIL load_add_count: got %0d required 4", insn_count);
        end
`endif
    endtask

    task automatic test_sub_inc_dec();
        clear_rom();
        rom[0] = ri(4'h8, 2'd1, 8'd7);
        rom[1] = rrr(4'h1, 2'd3, 2'd1, 2'd1);
        rom[2] = ri(4'hA, 2'd3, 8'h00);
        rom[3] = ri(4'hB, 2'd1, 8'h00);
        check_run("sub_inc_dec");
        checks++;
        if (regs[3] !== 8'd1 || regs[1] !== 8'd6) begin
            errors++;
            $display("[TB] FAIL sub_inc_dec_spec: R3=%0d R1=%0d required 1 6", regs[3], regs[1]);
        end
    endtask

    task automatic test_djnz();
        clear_rom();
        rom[0] = ri(4'h8, 2'd0, 8'd3);
        rom[1] = ri(4'hE, 2'd0, 8'd1);
        check_run("djnz");
        checks++;
        if (regs[0] !== 8'd0 || bus.pc !== 8'd2 || dut_cycles !== 3 + 3 * 5 + 2 - 1) begin
            errors++;
            $display("[TB] FAIL djnz_spec: R0=%0d pc=%0d cycles=%0d required 0 2 19",
                     regs[0], bus.pc, dut_cycles);
        end
        clear_rom();
        rom[0] = ri(4'hE, 2'd2, 8'd5);
        rom[1] = ri(4'h8, 2'd3, 8'h77);
        check_run("djnz_zero");
        checks++;
        if (regs[2] !== 8'd255 || bus.pc !== 8'd5) begin
            errors++;
            $display("[TB] FAIL djnz_zero_spec: R2=%0d pc=%0d required 255 5", regs[2], bus.pc);
        end
    endtask

    task automatic test_pc_wrap();
        clear_rom();
        rom[0]     = ri(4'hF, 2'd0, 8'hFF);
        rom[8'hFF] = ri(4'hF, 2'd0, 8'h10);
        check_run("jmp_255");
        checks++;
        if (bus.pc !== 8'h10) begin
            errors++;
            $display("[TB] FAIL jmp_255_spec: pc=%0d required 16", bus.pc);
        end
        clear_rom();
        init_regs[0] = 8'd2;
        rom[0]     = ri(4'hE, 2'd0, 8'hFF);
        rom[8'hFF] = 16'h5000;
        check_run("nop_255");
        checks++;
        if (saw_wrap !== 1'b1 || bus.pc !== 8'd1) begin
            errors++;
            $display("[TB] FAIL nop_255_wrap: wrap_seen=%0b pc=%0d required 1 1", saw_wrap, bus.pc);
        end
    endtask

    task automatic test_reset_in_wb();
        clear_rom();
        init_regs[2] = 8'hAA;
        rom[0] = ri(4'h8, 2'd0, 8'd5);
        rom[1] = ri(4'h8, 2'd1, 8'd3);
        rom[2] = rrr(4'h0, 2'd2, 2'd0, 2'd1);
        start_dut();
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (bus.alu_a !== 8'd5 || bus.alu_b !== 8'd3 || bus.pc !== 8'd2) begin
            errors++;
            $display("[TB] FAIL pre_wb_state: a=%0d b=%0d pc=%0d required 5 3 2",
                     bus.alu_a, bus.alu_b, bus.pc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pc, bus.ir_en, bus.reg_addr, bus.reg_rd, bus.reg_wr, bus.reg_din,
             bus.alu_opcode, bus.alu_a, bus.alu_b, halted} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: pc=%0d a=%0d b=%0d addr=%0d wr=%0b required all 0",
                     bus.pc, bus.alu_a, bus.alu_b, bus.reg_addr, bus.reg_wr);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (regs[2] !== 8'hAA || regs[0] !== 8'd5 || regs[1] !== 8'd3) begin
            errors++;
            $display("[TB] FAIL aborted_write: R0=%0d R1=%0d R2=%0d required 5 3 170",
                     regs[0], regs[1], regs[2]);
        end
`ifdef CU_INSN_COUNT_EN
        checks++;
        if (insn_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL abort_count: got %0d required 0", insn_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] w;
        int          n;
        int          k;
        int          u;
        bit          used_djnz;
        for (int t = 0; t < 8; t++) begin
            clear_rom();
            for (int i = 0; i < 4; i++) init_regs[i] = 8'($urandom);
            n = $urandom_range(6, 12);
            used_djnz = 1'b0;
            for (int a = 0; a < n; a++) begin
                w = 16'($urandom);
                k = $urandom_range(0, 7);
                case (k)
                    0: w[15:12] = 4'h0;
                    1: w[15:12] = 4'h1;
                    2: w[15:12] = 4'h8;
                    3: w[15:12] = 4'hA;
                    4: w[15:12] = 4'hB;
                    5: begin
                        if (!used_djnz) begin
                            w[15:12] = 4'hE;
                            w[7:0] = 8'(a);
                            used_djnz = 1'b1;
                        end else begin
                            w[15:12] = 4'h8;
                        end
                    end
                    6: begin
                        if (a + 2 <= n) begin
                            w[15:12] = 4'hF;
                            w[7:0] = 8'(a + 2);
                        end else begin
                            w[15:12] = 4'h0;
                        end
                    end
                    default: begin
                        u = $urandom_range(0, 7);
                        w[15:12] = (u < 6) ? 4'(u + 2) : ((u == 6) ? 4'h9 : 4'hD);
                    end
                endcase
                rom[a] = w;
            end
            check_run($sformatf("random%0d", t));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        reg_init = 1'b0;
        test_reset();
        test_load_add();
        test_sub_inc_dec();
        test_djnz();
        test_pc_wrap();
        test_reset_in_wb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Hardwired multi-cycle control unit for the 8-bit processor. Replaces bench-driven sequencing: fetches 16-bit instructions from the instruction ROM, decodes them, drives the 4-entry register file and the 3-bit-opcode ALU, and updates the program counter. Sits between `inst_reg`, `registers` and `alu` as the only master of their control inputs.

## Interface
- `PC_W`, 8, program counter / ROM address width
- `DATA_W`, 8, datapath width
- `clk`  input  1  system clock, rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `pc`  output  PC_W  instruction address to ROM
- `ir_en`  output  1  ROM read enable
- `ir_data`  input  16  instruction word, valid one cycle after `pc`/`ir_en`
- `reg_addr`  output  2  register file address
- `reg_rd`  output  1  register read strobe
- `reg_wr`  output  1  register write strobe
- `reg_din`  output  DATA_W  register write data
- `reg_dout`  input  DATA_W  register read data, valid one cycle after `reg_addr`/`reg_rd`
- `alu_opcode`  output  3  ALU operation
- `alu_a`, `alu_b`  output  DATA_W  ALU operands
- `alu_out`  input  DATA_W  ALU result (combinational)
- `halted`  output  1  high once HLT executed

## Operation
- Instruction fields: op=[15:12], rd=[9:8], rs1=[5:4], rs2=[1:0], imm/target=[7:0].
- Opcodes: 0000 ADD rd=rs1+rs2; 0001 SUB rd=rs1-rs2; 1000 LOAD rd=imm; 1010 INC rd=rd+1; 1011 DEC rd=rd-1; 1110 DJNZ rd=rd-1, jump to target if result≠0; 1111 JMP target; 1100 HLT. All other opcodes: NOP.
- ALU codes: add=000, sub=001; INC uses 000 with B=1, DEC/DJNZ use 001 with B=1.
- States: FETCH, DECODE, RD1, RD2, EXEC, WB, HALT.
  - FETCH: `ir_en`=1, drive `pc` → DECODE.
  - DECODE: latch `ir_data` into internal IR. LOAD → WB. JMP: pc←target → FETCH. HLT → HALT. NOP: pc←pc+1 → FETCH. ADD/SUB: read rs1 → RD1. INC/DEC/DJNZ: read rd → RD1.
  - RD1: `alu_a`←`reg_dout`. ADD/SUB: read rs2 → RD2. Else `alu_b`←1 → EXEC.
  - RD2: `alu_b`←`reg_dout` → EXEC.
  - EXEC: drive `alu_opcode`, result settles → WB.
  - WB: `reg_wr`=1 for one cycle, `reg_addr`=rd, `reg_din`=imm (LOAD) or `alu_out`. pc←target for DJNZ with nonzero result, else pc+1 → FETCH.
  - HALT: terminal, `halted`=1; exits only on reset.
- PC arithmetic modulo 2^PC_W: 255+1 wraps to 0. ALU results wrap mod 256; DJNZ on rd=0 yields 255 and jumps.
- `reg_rd` and `reg_wr` never high in the same cycle.

## Timing
- Reset values: `pc`=0, `ir_en`=0, `reg_addr`=0, `reg_rd`=0, `reg_wr`=0, `reg_din`=0, `alu_opcode`=0, `alu_a`=0, `alu_b`=0, `halted`=0, state=FETCH.
- Cycles per instruction: LOAD 3; ADD/SUB 6; INC/DEC/DJNZ 5; JMP/NOP 2; HLT 2, then stays in HALT.
- First FETCH is the first rising edge after `rst_n` deasserts.
- Reset mid-instruction aborts with no register write; outputs return to reset values immediately (async).
- `halted` asserts on the edge entering HALT and holds.

## Configuration
- `CU_INSN_COUNT_EN` defined: adds output `insn_count` (16 bits). Counts retired instructions, including HLT. Increments on the exit from WB or DECODE and on entering HALT. Wraps at 65535→0. Resets to 0.
- Undefined: no port and no counter logic; behaviour otherwise identical.

## Structure
- `cpu_pkg`: opcode localparams, ALU code localparams (ALU_ADD, ALU_SUB), instruction field bit positions, state enum.
- Sub-module `cu_decoder`: combinational; takes IR and produces instruction class, rd, rs1, rs2, imm, alu code and needs_rs2 / writes_rd / is_branch flags. The FSM lives in `cpu_control_unit`.

## Test plan
- ROM: LOAD R0,5; LOAD R1,3; ADD R2,R0,R1; HLT. Required: R2=8, `halted`=1, `pc`=3, 13 cycles from reset release to HALT.
- LOAD R1,7; SUB R3,R1,R1; INC R3; DEC R1; HLT. Required: R3=1, R1=6.
- LOAD R0,3; DJNZ R0,1; HLT. Required: DJNZ executes 3 times, R0=0, halts at pc=2.
- JMP at address 255 to 0x10, plus a NOP at 255. Required: JMP goes to 0x10; NOP at 255 wraps `pc` to 0.
- Assert `rst_n` low during WB of an ADD. Required: no write occurs and all outputs return to reset values asynchronously. With `CU_INSN_COUNT_EN` defined, `insn_count`=0 after reset and 4 after the first program.
